// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: bundle layouts, counter encodings and FSM states for branch resolution
package branch_resolve_unit_pkg;
  localparam int BRESULT_WD = 69;
  localparam int BPU_TO_DS_BUS_WD = 36;
  localparam int BPU_ADDR_LSB = 0;
  localparam int BPU_VALID_BIT = 32;
  localparam int BPU_COUNT_LSB = 33;
  localparam int BPU_TAKEN_BIT = 35;
  localparam int BR_TARGET_LSB = 0;
  localparam int BR_TAKEN_BIT = 32;
  localparam int BR_STALL_BIT = 33;
  localparam int BR_IS_BRANCH_BIT = 34;
  localparam int BR_COUNT_LSB = 35;
  localparam int BR_PC_LSB = 37;
  typedef enum logic [1:0] {
    W_TAKEN  = 2'b00,
    S_TAKEN  = 2'b01,
    WN_TAKEN = 2'b10,
    SN_TAKEN = 2'b11
  } bp_count_e;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_DS  = 2'b01,
    REDIRECT = 2'b10
  } br_state_e;
endpackage

// File: rtl/branch_resolve_unit_perf.sv
// br_perf_counters: wrapping resolved-branch and mispredict counters
module br_perf_counters #(
  parameter int CNT_WD = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_inc,
  input  logic              mis_inc,
  output logic [CNT_WD-1:0] br_cnt,
  output logic [CNT_WD-1:0] mispred_cnt
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else begin
      br_cnt      <= br_cnt + CNT_WD'(br_inc);
      mispred_cnt <= mispred_cnt + CNT_WD'(mis_inc);
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EXE-stage branch check, delay-slot-aware redirect and predictor update bundle
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int         PC_WD      = 32,
  parameter int         CNT_WD     = 32,
  parameter logic [1:0] MISS_COUNT = WN_TAKEN
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        es_valid,
  input  logic                        es_fire,
  input  logic [PC_WD-1:0]            es_pc,
  input  logic                        es_is_branch,
  input  logic                        es_br_taken,
  input  logic [PC_WD-1:0]            es_br_target,
  input  logic [BPU_TO_DS_BUS_WD-1:0] es_bpu_bus,
  input  logic                        ds_valid,
  input  logic                        fs_redirect_ready,
  output logic                        br_flush,
  output logic [PC_WD-1:0]            br_redirect_pc,
  output logic                        br_stall,
  output logic [BRESULT_WD-1:0]       BResult,
  output logic [CNT_WD-1:0]           br_cnt,
  output logic [CNT_WD-1:0]           mispred_cnt
);
  br_state_e        state;
  logic             pred_valid, r, m, unused_pred_taken;
  logic [1:0]       pred_count;
  logic [PC_WD-1:0] pred_addr, seq_pc, pred_npc, act_npc;
  // direction bit is implied by pred_addr when the predictor hit
  assign unused_pred_taken = es_bpu_bus[BPU_TAKEN_BIT];
  assign pred_valid = es_bpu_bus[BPU_VALID_BIT];
  assign pred_count = es_bpu_bus[BPU_COUNT_LSB +: 2];
  assign pred_addr  = es_bpu_bus[BPU_ADDR_LSB +: PC_WD];
  assign seq_pc     = es_pc + PC_WD'(8);
  assign pred_npc   = pred_valid ? pred_addr : seq_pc;
  assign act_npc    = es_br_taken ? es_br_target : seq_pc;
  assign r          = es_valid & es_fire & es_is_branch;
  assign m          = r & (pred_npc != act_npc);
  assign br_stall   = (state != IDLE) | m;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state          <= IDLE;
      br_flush       <= 1'b0;
      br_redirect_pc <= '0;
      BResult        <= '0;
    end else begin
      BResult <= r ? {es_pc, pred_valid ? pred_count : MISS_COUNT, 1'b1, m, es_br_taken, es_br_target} : '0;
      case (state)
        IDLE: if (m) begin
          br_redirect_pc <= act_npc;
          state          <= ds_valid ? REDIRECT : WAIT_DS;
          br_flush       <= ds_valid;
        end
        WAIT_DS: if (ds_valid) begin
          state    <= REDIRECT;
          br_flush <= 1'b1;
        end
        REDIRECT: if (fs_redirect_ready) begin
          state    <= IDLE;
          br_flush <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  br_perf_counters #(.CNT_WD(CNT_WD)) u_perf (
    .clk        (clk),
    .reset      (reset),
    .br_inc     (r),
    .mis_inc    (m),
    .br_cnt     (br_cnt),
    .mispred_cnt(mispred_cnt)
  );
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random stimulus against a transaction-level reference model
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        es_valid, es_fire, es_is_branch, es_br_taken, ds_valid, fs_redirect_ready;
  logic [31:0] es_pc, es_br_target;
  logic [35:0] es_bpu_bus;
  logic        br_flush, br_stall;
  logic [31:0] br_redirect_pc, br_cnt, mispred_cnt;
  logic [68:0] BResult;
  int n_tests = 0;
  int n_fail = 0;
  int mode;
  logic        busy_now;
  logic        m_flush;
  logic [31:0] m_rpc, m_br, m_mis;
  logic [68:0] m_bres;
  always #5 clk = ~clk;
  branch_resolve_unit dut (
    .clk(clk), .reset(reset), .es_valid(es_valid), .es_fire(es_fire), .es_pc(es_pc),
    .es_is_branch(es_is_branch), .es_br_taken(es_br_taken), .es_br_target(es_br_target),
    .es_bpu_bus(es_bpu_bus), .ds_valid(ds_valid), .fs_redirect_ready(fs_redirect_ready),
    .br_flush(br_flush), .br_redirect_pc(br_redirect_pc), .br_stall(br_stall),
    .BResult(BResult), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );
  always @(posedge clk)
    if (!reset) assert (!(es_valid && es_fire && es_is_branch && busy_now))
      else $error("FAIL protocol: branch resolved while redirect pending");
  task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [35:0] bus(input logic pt, input logic [1:0] cnt, input logic pv, input logic [31:0] addr);
    return {pt, cnt, pv, addr};
  endfunction
  task automatic model_reset();
    mode = 0;
    busy_now = 1'b0;
    m_flush = 1'b0;
    m_rpc = '0;
    m_br = '0;
    m_mis = '0;
    m_bres = '0;
  endtask
  // one clock cycle: drive, compare against the model, then advance the model
  task automatic step(input logic v, input logic f, input logic b, input logic tk,
                      input logic [31:0] pc, input logic [31:0] tg, input logic [35:0] bb,
                      input logic ds, input logic rdy);
    logic r, m;
    logic [31:0] pn, an;
    @(negedge clk);
    es_valid = v; es_fire = f; es_is_branch = b; es_br_taken = tk;
    es_pc = pc; es_br_target = tg; es_bpu_bus = bb; ds_valid = ds; fs_redirect_ready = rdy;
    #1;
    r  = v && f && b;
    pn = bb[32] ? bb[31:0] : pc + 32'd8;
    an = tk ? tg : pc + 32'd8;
    m  = r && (pn != an);
    busy_now = (mode != 0);
    expect_eq("bresult", BResult, m_bres);
    expect_eq("flush", br_flush, m_flush);
    if (m_flush) expect_eq("redirect_pc", br_redirect_pc, m_rpc);
    expect_eq("br_cnt", br_cnt, m_br);
    expect_eq("mispred_cnt", mispred_cnt, m_mis);
    expect_eq("stall", br_stall, busy_now || m);
    m_bres = r ? {pc, bb[32] ? bb[34:33] : 2'b10, 1'b1, m, tk, tg} : 69'd0;
    m_br  += 32'(r);
    m_mis += 32'(m);
    if (mode == 0 && m) begin
      m_rpc = an;
      mode = ds ? 2 : 1;
      m_flush = ds;
    end else if (mode == 1 && ds) begin
      mode = 2;
      m_flush = 1'b1;
    end else if (mode == 2 && rdy) begin
      mode = 0;
      m_flush = 1'b0;
    end
  endtask
  task automatic idle(input logic ds, input logic rdy);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 36'd0, ds, rdy);
  endtask
  initial begin
    logic [68:0] exp_b;
    reset = 1'b1;
    es_valid = 0; es_fire = 0; es_is_branch = 0; es_br_taken = 0;
    es_pc = 0; es_br_target = 0; es_bpu_bus = 0; ds_valid = 0; fs_redirect_ready = 0;
    model_reset();
    #1;
    expect_eq("reset_flush", br_flush, 1'b0);
    expect_eq("reset_bresult", BResult, 69'd0);
    expect_eq("reset_stall", br_stall, 1'b0);
    expect_eq("reset_cnt", br_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    // correct taken hit
    step(1, 1, 1, 1, 32'hBFC00100, 32'hBFC00200, bus(1, 2'b01, 1, 32'hBFC00200), 1, 1);
    idle(1, 1);
    exp_b = {32'hBFC00100, 2'b01, 1'b1, 1'b0, 1'b1, 32'hBFC00200};
    expect_eq("hit_bresult", BResult, exp_b);
    expect_eq("hit_flush", br_flush, 1'b0);
    expect_eq("hit_br_cnt", br_cnt, 32'd1);
    expect_eq("hit_mis_cnt", mispred_cnt, 32'd0);
    // predictor miss, taken, delay slot present
    step(1, 1, 1, 1, 32'h80000010, 32'h80000400, bus(0, 2'b00, 0, 32'h0), 1, 0);
    expect_eq("miss_stall", br_stall, 1'b1);
    idle(1, 1);
    exp_b = {32'h80000010, 2'b10, 1'b1, 1'b1, 1'b1, 32'h80000400};
    expect_eq("miss_bresult", BResult, exp_b);
    expect_eq("miss_flush", br_flush, 1'b1);
    expect_eq("miss_redirect", br_redirect_pc, 32'h80000400);
    idle(1, 1);
    expect_eq("miss_release", br_flush, 1'b0);
    // predicted taken, actually not taken, delay slot late
    step(1, 1, 1, 0, 32'h00001000, 32'h00001200, bus(1, 2'b00, 1, 32'h00001200), 0, 1);
    repeat (3) idle(0, 1);
    expect_eq("wait_ds_stall", br_stall, 1'b1);
    idle(1, 1);
    idle(1, 1);
    expect_eq("dir_redirect", br_redirect_pc, 32'h00001008);
    expect_eq("dir_flush", br_flush, 1'b1);
    idle(1, 1);
    // target mismatch
    step(1, 1, 1, 1, 32'h00001800, 32'h00003000, bus(1, 2'b00, 1, 32'h00002000), 1, 1);
    idle(1, 1);
    expect_eq("tgt_redirect", br_redirect_pc, 32'h00003000);
    expect_eq("tgt_mis_cnt", mispred_cnt, 32'd3);
    idle(1, 1);
    // redirect back-pressure
    step(1, 1, 1, 0, 32'h00004000, 32'h00005000, bus(1, 2'b11, 1, 32'h00005000), 1, 0);
    repeat (4) idle(1, 0);
    idle(1, 1);
    expect_eq("hold_flush", br_flush, 1'b1);
    expect_eq("hold_redirect", br_redirect_pc, 32'h00004008);
    idle(1, 1);
    // asynchronous reset in the middle of a redirect
    step(1, 1, 1, 1, 32'h00006000, 32'h00007000, bus(0, 2'b00, 0, 32'h0), 1, 0);
    idle(1, 0);
    #2 reset = 1'b1;
    #1;
    expect_eq("areset_flush", br_flush, 1'b0);
    expect_eq("areset_redirect", br_redirect_pc, 32'd0);
    expect_eq("areset_stall", br_stall, 1'b0);
    expect_eq("areset_cnt", mispred_cnt, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) step(1, 1, 0, 1, 32'h00008000, 32'h00009000, 36'd0, 1, 0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic v, f, b, tk, pv, ds, rdy;
      logic [31:0] pc, tg, pa;
      v  = ($urandom % 4) != 0;
      f  = (mode == 0) && (($urandom % 4) != 0);
      b  = $urandom % 2;
      tk = $urandom % 2;
      pc = $urandom & 32'hFFFFFFFC;
      if ($urandom % 8 == 0) pc = 32'hFFFFFFFC;
      tg = $urandom & 32'hFFFFFFFC;
      pv = ($urandom % 4) != 0;
      pa = ($urandom % 2) ? (tk ? tg : pc + 32'd8) : (($urandom % 2) ? pc + 32'd8 : tg);
      ds  = ($urandom % 3) != 0;
      rdy = $urandom % 2;
      step(v, f, b, tk, pc, tg, bus(1'($urandom), 2'($urandom), pv, pa), ds, rdy);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EXE-stage branch resolution unit: the update side of the branch predictor protocol.
- Consumes the predictor bundle carried down the pipe with each instruction (BPU_to_ds_bus format) and compares it against the actual branch outcome computed in EXE.
- On a misprediction it drives a flush/redirect to fetch, honouring the MIPS delay slot.
- Emits the registered BResult update bundle consumed by the predictor, and keeps branch/mispredict performance counters.

Parameters:
- PC_WD, 32, address width
- CNT_WD, 32, perf counter width
- MISS_COUNT, 2'b10, counter value reported for predictor-miss branches (weakly not-taken)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- es_valid  in  1  EXE holds a valid instruction
- es_fire  in  1  EXE instruction advances this cycle; ignored unless es_valid
- es_pc  in  32  PC of the EXE instruction
- es_is_branch  in  1  instruction is a branch or jump
- es_br_taken  in  1  actual direction
- es_br_target  in  32  actual target
- es_bpu_bus  in  36  {pred_taken, pred_count[1:0], pred_valid, pred_addr[31:0]}
- ds_valid  in  1  delay-slot instruction present in ID or later
- fs_redirect_ready  in  1  fetch accepts redirect this cycle
- br_flush  out  1  flush younger-than-delay-slot instructions and redirect
- br_redirect_pc  out  32  correct next PC
- br_stall  out  1  EXE must not fire another branch
- BResult  out  BRESULT_WD(69)  {pc32, old_count2, is_branch1, br_stall1, taken1, target32}
- br_cnt  out  CNT_WD  resolved branches
- mispred_cnt  out  CNT_WD  mispredicted branches

Behaviour:
- Resolve event R = es_valid & es_fire & es_is_branch.
- Predicted next PC:
  - pred_valid=1: pred_addr.
  - pred_valid=0: es_pc+8.
- Actual next PC: es_br_taken ? es_br_target : es_pc+8. All adds are mod 2^32.
- Mispredict M = R & (predicted next PC != actual next PC). This covers direction errors, target errors, and predictor-miss branches that are taken.
- BResult is a register updated every cycle:
  - On R: {es_pc, pred_valid ? pred_count : MISS_COUNT, 1, M, es_br_taken, es_br_target}.
  - Otherwise: all zero. is_branch therefore pulses exactly one cycle, one cycle after R.
- FSM states IDLE, WAIT_DS, REDIRECT. Redirect PC is latched on M.
  - IDLE: on M, go to REDIRECT if ds_valid, else WAIT_DS.
  - WAIT_DS: go to REDIRECT when ds_valid=1.
  - REDIRECT: br_flush=1 with br_redirect_pc held. Stay until fs_redirect_ready; on that cycle return to IDLE. The flush lasts one cycle when ready is already high.
- br_stall = (state != IDLE) | M. It is combinational on M so a back-to-back branch cannot resolve in the M cycle.
- R while not IDLE is a protocol violation. br_stall forbids it; the bench asserts it never occurs.
- Counters:
  - br_cnt increments on R.
  - mispred_cnt increments on M.
  - Both wrap at 2^CNT_WD.
- Reset (asynchronous, any time including mid-REDIRECT):
  - state=IDLE; br_flush=0, br_redirect_pc=0, br_stall=0, BResult=0, counters=0.
  - No flush is issued after reset deasserts.
- br_flush and br_redirect_pc are registered outputs. First flush cycle is at the earliest the cycle after M (IDLE→REDIRECT transition edge).

Decomposition:
- Shared package / global_defines.vh holds:
  - BRESULT_WD (69) and BPU_TO_DS_BUS_WD (36)
  - Bundle field offsets
  - Counter encodings W_Taken=00, S_Taken=01, WN_Taken=10, SN_Taken=11
  - FSM state encoding
- One natural sub-module: br_perf_counters (two wrapping counters with enables).

Test Plan:
- Correct taken hit: pc=0xBFC00100, bus pred_valid=1, pred_taken=1, pred_count=01, pred_addr=0xBFC00200; actual taken to 0xBFC00200 -> no flush; next-cycle BResult={0xBFC00100,01,1,0,1,0xBFC00200}; br_cnt=1, mispred_cnt=0.
- Predictor miss, taken, ds_valid=1: pc=0x80000010, pred_valid=0, target 0x80000400 -> BResult old_count=10, br_stall=1; br_flush=1 next cycle with redirect 0x80000400; return to IDLE with fs_redirect_ready=1.
- Predicted taken, actually not taken, ds_valid=0 for 3 cycles: pc=0x1000 -> stays WAIT_DS, no flush, br_stall=1; after ds_valid rises, flush with redirect 0x1008.
- Target mismatch: predicted 0x2000, actual taken 0x3000 -> flush to 0x3000; mispred_cnt increments.
- fs_redirect_ready low 4 cycles -> br_flush and br_redirect_pc held stable 4 cycles, released the cycle after ready.
- Reset asserted mid-REDIRECT -> outputs zero immediately (asynchronous); no flush after release; counters=0; non-branch es_fire cycles leave BResult zero.
